// File: rtl/dct_block_scheduler_if.sv
// Handshake and engine bus bundle for dct_block_scheduler.
// master = scheduler side, slave = pixel source / engine / consumer side.
interface dct_block_scheduler_if;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned MAT_W  = 1024;
    localparam int unsigned CNT_W  = 16;

    logic [PIX_W-1:0]  in_pixel;
    logic              in_valid;
    logic              in_ready;
    logic [MAT_W-1:0]  coef;
    logic              eng_reset;
    logic              eng_enable;
    logic [MAT_W-1:0]  eng_A;
    logic [MAT_W-1:0]  eng_B;
    logic [MAT_W-1:0]  eng_C;
    logic              eng_done;
    logic [WORD_W-1:0] out_coef;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic              err;
    logic [CNT_W-1:0]  block_count;

    modport master (
        input  in_pixel, in_valid, coef, eng_C, eng_done, out_ready,
        output in_ready, eng_reset, eng_enable, eng_A, eng_B,
               out_coef, out_valid, out_last, busy, err, block_count
    );

    modport slave (
        output in_pixel, in_valid, coef, eng_C, eng_done, out_ready,
        input  in_ready, eng_reset, eng_enable, eng_A, eng_B,
               out_coef, out_valid, out_last, busy, err, block_count
    );
endinterface

// File: rtl/dct_block_scheduler.sv
// Ping-pong pixel buffering, engine sequencing with hang timeout, and
// coefficient streaming for the 8x8 DCT matrix-multiply engine.
module dct_block_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 2048
) (
    input logic                   Clock,
    input logic                   reset_n,
    dct_block_scheduler_if.master bus
);
    localparam int unsigned N_PIX  = 64;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state;
    logic [PIX_W-1:0]          pix_buf [2][N_PIX];
    logic [WORD_W-1:0]         out_buf [N_PIX];
    logic [1:0]                full_q;
    logic [1:0]                full_d;
    logic                      fill_sel;
    logic                      fill_sel_d;
    logic                      run_sel;
    logic [IDX_W-1:0]          fill_idx;
    logic [IDX_W-1:0]          out_idx;
    logic [TO_W-1:0]           tcount;
    logic                      in_ready_q;
    logic                      eng_reset_q;
    logic                      eng_enable_q;
    logic                      out_valid_q;
    logic                      out_last_q;
    logic                      busy_q;
    logic                      err_q;
    logic [WORD_W-1:0]         out_coef_q;
    logic [CNT_W-1:0]          block_count_q;
    logic [N_PIX*WORD_W-1:0]   eng_a_q;
    logic                      accept;
    logic                      start;
    logic                      done_ev;
    logic                      timeout_ev;
    logic                      finish;
    logic                      drain;

    // Event decode and next full-flag / fill-select values
    always_comb begin
        accept     = bus.in_valid && in_ready_q;
        start      = (state == IDLE) && full_q[run_sel] && !out_valid_q;
        done_ev    = (state == RUN) && bus.eng_done;
        timeout_ev = (state == RUN) && !bus.eng_done &&
                     (tcount == TO_W'(TIMEOUT_CYCLES - 1));
        finish     = done_ev || timeout_ev;
        drain      = out_valid_q && bus.out_ready;
        full_d     = full_q;
        fill_sel_d = fill_sel;
        if (accept && (fill_idx == LAST_IDX)) begin
            full_d[fill_sel] = 1'b1;
            fill_sel_d       = ~fill_sel;
        end
        if (finish) begin
            full_d[run_sel] = 1'b0;
        end
    end

    // Control state, registered outputs and output stream pointer
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            full_q        <= '0;
            fill_sel      <= 1'b0;
            run_sel       <= 1'b0;
            fill_idx      <= '0;
            out_idx       <= '0;
            tcount        <= '0;
            in_ready_q    <= 1'b0;
            eng_reset_q   <= 1'b1;
            eng_enable_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            out_coef_q    <= '0;
            block_count_q <= '0;
        end else begin
            full_q     <= full_d;
            fill_sel   <= fill_sel_d;
            in_ready_q <= ~full_d[fill_sel_d];
            if (accept) begin
                fill_idx <= fill_idx + IDX_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        tcount       <= '0;
                        busy_q       <= 1'b1;
                        eng_reset_q  <= 1'b0;
                        eng_enable_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (finish) begin
                        state        <= IDLE;
                        busy_q       <= 1'b0;
                        eng_reset_q  <= 1'b1;
                        eng_enable_q <= 1'b0;
                        run_sel      <= ~run_sel;
                    end else begin
                        tcount <= tcount + TO_W'(1);
                    end
                    if (done_ev) begin
                        block_count_q <= block_count_q + CNT_W'(1);
                    end
                    if (timeout_ev) begin
                        err_q <= 1'b1;
                    end
                end
            endcase

            // A load and a drain handshake never coincide: RUN needs an empty output buffer
            if (done_ev) begin
                out_valid_q <= 1'b1;
                out_idx     <= '0;
                out_last_q  <= 1'b0;
                out_coef_q  <= bus.eng_C[WORD_W-1:0];
            end else if (drain) begin
                if (out_idx == LAST_IDX) begin
                    out_valid_q <= 1'b0;
                    out_idx     <= '0;
                    out_last_q  <= 1'b0;
                end else begin
                    out_idx    <= out_idx + IDX_W'(1);
                    out_coef_q <= out_buf[out_idx + IDX_W'(1)];
                    out_last_q <= (out_idx == LAST_IDX - IDX_W'(1));
                end
            end
        end
    end

    // Data storage needs no reset; validity is tracked by the flags above
    always_ff @(posedge Clock) begin
        if (accept) begin
            pix_buf[fill_sel][fill_idx] <= bus.in_pixel;
        end
        if (start) begin
            for (int unsigned n = 0; n < N_PIX; n++) begin
                eng_a_q[n*WORD_W +: WORD_W] <= {{(WORD_W-PIX_W){1'b0}}, pix_buf[run_sel][n]};
            end
        end
        if (done_ev) begin
            for (int unsigned n = 0; n < N_PIX; n++) begin
                out_buf[n] <= bus.eng_C[n*WORD_W +: WORD_W];
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.eng_reset   = eng_reset_q;
    assign bus.eng_enable  = eng_enable_q;
    assign bus.eng_A       = eng_a_q;
    assign bus.eng_B       = bus.coef;
    assign bus.out_coef    = out_coef_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
    assign bus.block_count = block_count_q;
endmodule

// File: tb/tb_dct_block_scheduler.sv
// Bench for dct_block_scheduler: engine stub with programmable latency/hang,
// stream-level reference model, table-driven blocks plus random and reset sequences.
module tb_dct_block_scheduler;
    localparam int TO = 1100;

    logic Clock;
    logic reset_n;
    dct_block_scheduler_if bus();

    dct_block_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .Clock   (Clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit active = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;
    always @(posedge Clock or negedge reset_n)
        if (!reset_n) active <= 1'b0;
        else          active <= 1'b1;

    // Engine stub: done after eng_lat enabled edges; C[n] = A[n]*7 + B[n]
    int  eng_lat  = 5;
    int  e_lat    = 5;
    int  e_cnt    = 0;
    bit  eng_hang = 1'b0;
    bit  lat_rand = 1'b0;
    always @(posedge Clock) begin
        if (bus.eng_reset) begin
            e_cnt        <= 0;
            bus.eng_done <= 1'b0;
            e_lat        <= lat_rand ? int'($urandom_range(1, 40)) : eng_lat;
        end else if (bus.eng_enable) begin
            e_cnt <= e_cnt + 1;
            if (!eng_hang && e_cnt == e_lat - 1) begin
                bus.eng_done <= 1'b1;
                for (int n = 0; n < 64; n++)
                    bus.eng_C[n*16 +: 16] <= 16'(bus.eng_A[n*16 +: 16] * 16'd7) + bus.eng_B[n*16 +: 16];
            end
        end
    end

    // Reference model state
    logic [7:0]    pix_q[$];
    logic [15:0]   exp_q[$];
    int            n_full   = 0;
    int            ow       = 0;
    int            last_acc = 0;
    int            lat_exp  = 0;
    bit            chk_lat  = 1'b0;
    bit            prev_busy, prev_valid, prev_err;
    logic [1023:0] a_cap;
    int            or_mode  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic ready_drv();
        bus.out_ready = 1'b1;
        forever begin
            @(posedge Clock); #1;
            case (or_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge Clock);
            if (!reset_n) begin
                pix_q.delete(); exp_q.delete();
                n_full = 0; ow = 0;
                prev_busy = 1'b0; prev_valid = 1'b0; prev_err = 1'b0;
            end else if (active) begin
                chk("eng_ctl", {29'd0, bus.eng_enable, bus.eng_reset, bus.busy},
                    {29'd0, bus.busy, !bus.busy, bus.busy});
                chk("run_vs_drain", 32'(bus.busy && bus.out_valid), 32'd0);
                checks++;
                if (bus.eng_B !== bus.coef) begin
                    errors++; $display("FAIL eng_B: pass-through differs from coef");
                end
                if (bus.busy && !prev_busy) a_cap = bus.eng_A;
                else if (bus.busy) begin
                    checks++;
                    if (bus.eng_A !== a_cap) begin
                        errors++; $display("FAIL eng_A_stable: changed during RUN");
                    end
                end
                if (prev_busy && !bus.busy) n_full--;
                chk("in_ready", 32'(bus.in_ready), 32'(n_full < 2));
                if (bus.in_valid && bus.in_ready) begin
                    pix_q.push_back(bus.in_pixel);
                    if (pix_q.size() == 64) begin
                        for (int n = 0; n < 64; n++)
                            exp_q.push_back(16'(16'(pix_q[n]) * 16'd7) + bus.coef[n*16 +: 16]);
                        pix_q.delete();
                        n_full++;
                        last_acc = cyc + 1;
                    end
                end
                if (chk_lat && bus.out_valid && !prev_valid)
                    chk("out_latency", 32'(cyc - last_acc), 32'(lat_exp + 2));
                if (chk_lat && bus.err && !prev_err)
                    chk("timeout_latency", 32'(cyc - last_acc), 32'(TO + 1));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_out: got %0h expected no output", bus.out_coef);
                    end else begin
                        chk("out_coef", 32'(bus.out_coef), 32'(exp_q.pop_front()));
                        chk("out_last", 32'(bus.out_last), 32'(ow == 63));
                    end
                    ow = (ow + 1) % 64;
                end
                prev_busy  = bus.busy;
                prev_valid = bus.out_valid;
                prev_err   = bus.err;
            end
        end
    endtask

    task automatic send_block(input logic [7:0] base, input logic [7:0] step, input bit gaps);
        int  n = 0;
        int  guard = 0;
        bit  acc;
        while (n < 64 && guard < 5000) begin
            if (gaps && $urandom_range(0, 3) == 0) bus.in_valid = 1'b0;
            else begin
                bus.in_valid = 1'b1;
                bus.in_pixel = 8'(int'(base) + int'(step) * n);
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge Clock); #1;
            if (acc) n++;
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("send_block", 32'(n), 32'd64);
    endtask

    task automatic wait_drain(input int bound);
        int k = 0;
        while ((exp_q.size() != 0 || bus.out_valid || bus.busy) && k < bound) begin
            @(posedge Clock); #1; k++;
        end
        chk("drain_bound", 32'(k < bound), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  step;
        int          lat;
        int          bp;
        bit          hang;
        logic [15:0] exp_count;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{base: 8'd128, step: 8'd0,   lat: 1025, bp: 0, hang: 1'b0, exp_count: 16'd1, exp_err: 1'b0};
        vecs[1] = '{base: 8'd3,   step: 8'd5,   lat: 10,   bp: 1, hang: 1'b0, exp_count: 16'd2, exp_err: 1'b0};
        vecs[2] = '{base: 8'd255, step: 8'd255, lat: 1,    bp: 2, hang: 1'b0, exp_count: 16'd3, exp_err: 1'b0};
        vecs[3] = '{base: 8'd0,   step: 8'd1,   lat: 10,   bp: 0, hang: 1'b1, exp_count: 16'd3, exp_err: 1'b1};
        vecs[4] = '{base: 8'd77,  step: 8'd13,  lat: 20,   bp: 1, hang: 1'b0, exp_count: 16'd4, exp_err: 1'b1};
        vecs[5] = '{base: 8'd250, step: 8'd7,   lat: 1099, bp: 0, hang: 1'b0, exp_count: 16'd5, exp_err: 1'b1};

        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        for (int n = 0; n < 64; n++) bus.coef[n*16 +: 16] = 16'($urandom);
        fork
            monitor();
            ready_drv();
        join_none

        repeat (3) @(posedge Clock);
        #1;
        chk("rst_eng_reset",   32'(bus.eng_reset),   32'd1);
        chk("rst_eng_enable",  32'(bus.eng_enable),  32'd0);
        chk("rst_in_ready",    32'(bus.in_ready),    32'd0);
        chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
        chk("rst_out_last",    32'(bus.out_last),    32'd0);
        chk("rst_out_coef",    32'(bus.out_coef),    32'd0);
        chk("rst_busy",        32'(bus.busy),        32'd0);
        chk("rst_err",         32'(bus.err),         32'd0);
        chk("rst_block_count", 32'(bus.block_count), 32'd0);
        reset_n = 1'b1;
        @(posedge Clock); #1;
        chk("in_ready_release", 32'(bus.in_ready), 32'd1);

        // Directed blocks, engine always free at start
        for (int i = 0; i < 6; i++) begin
            or_mode  = vecs[i].bp;
            eng_lat  = vecs[i].lat;
            lat_exp  = vecs[i].lat;
            eng_hang = vecs[i].hang;
            chk_lat  = 1'b1;
            repeat (2) @(posedge Clock);
            #1;
            send_block(vecs[i].base, vecs[i].step, 1'b0);
            if (vecs[i].hang) begin
                int k = 0;
                while (!bus.err && k < 3000) begin @(posedge Clock); #1; k++; end
                chk("err_bound", 32'(k < 3000), 32'd1);
                for (int j = 0; j < 64; j++) if (exp_q.size() > 0) void'(exp_q.pop_back());
                repeat (2) @(posedge Clock);
                #1;
                chk("hang_idle", 32'(bus.busy), 32'd0);
                chk("hang_no_out", 32'(bus.out_valid), 32'd0);
            end else begin
                wait_drain(3000);
            end
            chk("vec_block_count", 32'(bus.block_count), 32'(vecs[i].exp_count));
            chk("vec_err", 32'(bus.err), 32'(vecs[i].exp_err));
            eng_hang = 1'b0;
        end

        // Randomised back-to-back blocks with gaps, backpressure and varying engine latency
        chk_lat  = 1'b0;
        lat_rand = 1'b1;
        or_mode  = 2;
        for (int b = 0; b < 12; b++)
            send_block(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
        wait_drain(8000);
        chk("rand_block_count", 32'(bus.block_count), 32'd17);

        // Reset in the middle of a RUN
        lat_rand = 1'b0;
        eng_lat  = 1025;
        or_mode  = 0;
        send_block(8'd9, 8'd1, 1'b0);
        begin
            int k = 0;
            while (!bus.busy && k < 10) begin @(posedge Clock); #1; k++; end
            chk("run_started", 32'(bus.busy), 32'd1);
        end
        repeat (500) @(posedge Clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_eng_enable", 32'(bus.eng_enable), 32'd0);
        chk("midrst_eng_reset",  32'(bus.eng_reset),  32'd1);
        chk("midrst_busy",       32'(bus.busy),       32'd0);
        chk("midrst_in_ready",   32'(bus.in_ready),   32'd0);
        chk("midrst_err",        32'(bus.err),        32'd0);
        chk("midrst_count",      32'(bus.block_count), 32'd0);
        @(posedge Clock); #1;
        reset_n = 1'b1;
        @(posedge Clock); #1;
        chk("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_out_coef",  32'(bus.out_coef),  32'd0);
        chk("post_rst_out_last",  32'(bus.out_last),  32'd0);

        eng_lat = 30;
        lat_exp = 30;
        chk_lat = 1'b1;
        send_block(8'd200, 8'd3, 1'b0);
        wait_drain(3000);
        chk("fresh_block_count", 32'(bus.block_count), 32'd1);
        chk("fresh_err", 32'(bus.err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
